// File: rtl/tmds_decoder_dvi_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : tmds_decoder_dvi_rx_if
// Brief    : Raw TMDS word in, decoded symbol/alignment status out.
// Revision : 1.0 - initial release
// ============================================================================
interface tmds_decoder_dvi_rx_if;
  logic [9:0] tmds_in;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de;
  logic       locked;
  logic [3:0] bit_shift;

  modport master (
    output tmds_in,
    input  data_out, ctrl_out, de, locked, bit_shift
  );

  modport slave (
    input  tmds_in,
    output data_out, ctrl_out, de, locked, bit_shift
  );
endinterface
`default_nettype wire

// File: rtl/tmds_decoder_dvi_rx.sv
`default_nettype none
// ============================================================================
// Module   : tmds_decoder_dvi_rx
// Brief    : TMDS channel decoder; hunts symbol boundary on control-token runs.
// Revision : 1.0 - initial release
// ============================================================================
module tmds_decoder_dvi_rx #(
  parameter int TOKEN_RUN      = 16,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 8192
) (
  input  wire logic             clk_pix,
  input  wire logic             rst,
  tmds_decoder_dvi_rx_if.slave  bus
);
  localparam int RUN_W  = $clog2(TOKEN_RUN) + 1;
  localparam int TMR_W  = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT) + 1;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state;
  logic [9:0]        tmds_prev;
  logic [9:0]        aligned;
  logic [18:0]       window;
  logic [9:0]        win_sel;
  logic [RUN_W-1:0]  run_cnt;
  logic [TMR_W-1:0]  timer;
  logic [LOSS_W-1:0] loss_cnt;
  logic              blank;
  logic [3:0]        bit_shift_r;
  logic [7:0]        data_r;
  logic [1:0]        ctrl_r;
  logic              de_r;
  logic              locked_r;

  logic              is_token;
  logic [1:0]        token_val;
  logic [7:0]        q;
  logic [7:0]        dec;
  logic              lock_hit;
  logic              loss_hit;
  logic              next_locked;

  // Top bit of the newest word can never fall inside a 10-bit slice at offset <= 9.
  assign window = {bus.tmds_in[8:0], tmds_prev};

  always_comb begin
    win_sel = window[9:0];
    for (int i = 0; i < 10; i++) begin
      if (bit_shift_r == 4'(i)) win_sel = window[i +: 10];
    end
  end

  always_comb begin
    is_token  = 1'b1;
    token_val = 2'b00;
    case (aligned)
      10'b1101010100: token_val = 2'b00;
      10'b0010101011: token_val = 2'b01;
      10'b0101010100: token_val = 2'b10;
      10'b1010101011: token_val = 2'b11;
      default:        is_token  = 1'b0;
    endcase
  end

  always_comb begin
    q      = aligned[9] ? ~aligned[7:0] : aligned[7:0];
    dec    = 8'd0;
    dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = aligned[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  // The cycle right after a shift change carries a stale-offset word and is blanked.
  always_comb begin
    lock_hit    = (state == SEARCH) && !blank && is_token &&
                  (run_cnt == RUN_W'(TOKEN_RUN - 1));
    loss_hit    = (state == LOCKED) && !is_token &&
                  (loss_cnt == LOSS_W'(LOSS_TIMEOUT - 1));
    next_locked = (state == LOCKED) ? !loss_hit : lock_hit;
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      tmds_prev   <= 10'd0;
      aligned     <= 10'd0;
      run_cnt     <= '0;
      timer       <= '0;
      loss_cnt    <= '0;
      blank       <= 1'b0;
      bit_shift_r <= 4'd0;
      data_r      <= 8'd0;
      ctrl_r      <= 2'b00;
      de_r        <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      tmds_prev <= bus.tmds_in;
      aligned   <= win_sel;
      blank     <= 1'b0;

      case (state)
        SEARCH: begin
          if (lock_hit) begin
            state    <= LOCKED;
            run_cnt  <= '0;
            timer    <= '0;
            loss_cnt <= '0;
          end else if (timer == TMR_W'(SEARCH_TIMEOUT - 1)) begin
            bit_shift_r <= (bit_shift_r == 4'd9) ? 4'd0 : bit_shift_r + 4'd1;
            timer       <= '0;
            run_cnt     <= '0;
            blank       <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
            if (!blank) begin
              if (!is_token)          run_cnt <= '0;
              else if (run_cnt != '1) run_cnt <= run_cnt + RUN_W'(1);
            end
          end
        end
        LOCKED: begin
          if (is_token) begin
            loss_cnt <= '0;
          end else if (loss_hit) begin
            state    <= SEARCH;
            loss_cnt <= '0;
            timer    <= '0;
            run_cnt  <= '0;
          end else begin
            loss_cnt <= loss_cnt + LOSS_W'(1);
          end
        end
        default: state <= SEARCH;
      endcase

      locked_r <= next_locked;
      if (!next_locked) begin
        de_r   <= 1'b0;
        data_r <= 8'd0;
        ctrl_r <= 2'b00;
      end else if (is_token) begin
        de_r   <= 1'b0;
        data_r <= 8'd0;
        ctrl_r <= token_val;
      end else begin
        de_r   <= 1'b1;
        data_r <= dec;
      end
    end
  end

  assign bus.data_out  = data_r;
  assign bus.ctrl_out  = ctrl_r;
  assign bus.de        = de_r;
  assign bus.locked    = locked_r;
  assign bus.bit_shift = bit_shift_r;
endmodule
`default_nettype wire

// File: tb/tb_tmds_decoder_dvi_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmds_decoder_dvi_rx
// Brief    : Self-checking bench: TMDS encoder stimulus vs word-level lock model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_decoder_dvi_rx;
  localparam int TOKEN_RUN    = 16;
  localparam int LOSS_TIMEOUT = 8192;
  localparam logic [9:0] TOK [0:3] = '{10'b1101010100, 10'b0010101011,
                                       10'b0101010100, 10'b1010101011};

  logic clk_pix = 1'b0;
  logic rst     = 1'b1;

  tmds_decoder_dvi_rx_if bus ();

  tmds_decoder_dvi_rx dut (
    .clk_pix (clk_pix),
    .rst     (rst),
    .bus     (bus.slave)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct packed {
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       lk;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t expq[$];

  // Word-level reference: lock after TOKEN_RUN tokens, drop after LOSS_TIMEOUT non-tokens.
  bit         m_locked;
  int         m_run;
  int         m_loss;
  logic [1:0] m_ctrl;

  function automatic int tok_idx(input logic [9:0] w);
    for (int i = 0; i < 4; i++) if (w == TOK[i]) return i;
    return -1;
  endfunction

  function automatic logic [9:0] enc(input logic [7:0] d, input bit use_xor, input bit inv);
    logic [8:0] qm;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xor ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
    qm[8] = use_xor;
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  function automatic logic [9:0] enc_data(input logic [7:0] d);
    logic [9:0] w;
    for (int k = 0; k < 8; k++) begin
      w = enc(d, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      if (tok_idx(w) < 0) return w;
    end
    for (int k = 0; k < 4; k++) begin
      w = enc(d, bit'(k[0]), bit'(k[1]));
      if (tok_idx(w) < 0) return w;
    end
    return w;
  endfunction

  function automatic exp_t model_step(input logic [9:0] w, input logic [7:0] src);
    exp_t e;
    int   t;
    t = tok_idx(w);
    if (!m_locked) begin
      if (t >= 0) begin
        m_run++;
        if (m_run == TOKEN_RUN) begin
          m_locked = 1'b1;
          m_loss   = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (t >= 0) m_loss = 0;
      else begin
        m_loss++;
        if (m_loss == LOSS_TIMEOUT) begin
          m_locked = 1'b0;
          m_run    = 0;
          m_loss   = 0;
        end
      end
    end
    if (!m_locked) m_ctrl = 2'b00;
    else if (t >= 0) m_ctrl = 2'(t);
    e.lk   = m_locked;
    e.de   = m_locked && (t < 0);
    e.data = (m_locked && t < 0) ? src : 8'h00;
    e.ctrl = m_ctrl;
    return e;
  endfunction

  // Reset clears the two pipeline registers ahead of the output to zero words.
  task automatic model_reset();
    exp_t e;
    m_locked = 1'b0;
    m_run    = 0;
    m_loss   = 0;
    m_ctrl   = 2'b00;
    expq.delete();
    repeat (2) begin
      e = model_step(10'd0, 8'd0);
      expq.push_back(e);
    end
  endtask

  task automatic tick(input logic [9:0] w, input logic [7:0] src, input string tag);
    exp_t e;
    bus.tmds_in = w;
    @(posedge clk_pix);
    #1;
    expq.push_back(model_step(w, src));
    e = expq.pop_front();
    n_checks++;
    assert ({bus.de, bus.data_out, bus.ctrl_out, bus.locked, bus.bit_shift} ===
            {e.de, e.data, e.ctrl, e.lk, 4'd0})
    else begin
      n_fail++;
      $error("FAIL %s: got de=%b data=%h ctrl=%b locked=%b shift=%0d, expected de=%b data=%h ctrl=%b locked=%b shift=0",
             tag, bus.de, bus.data_out, bus.ctrl_out, bus.locked, bus.bit_shift,
             e.de, e.data, e.ctrl, e.lk);
    end
  endtask

  task automatic check_zero(input string tag);
    n_checks++;
    assert ({bus.de, bus.data_out, bus.ctrl_out, bus.locked, bus.bit_shift} === 16'd0)
    else begin
      n_fail++;
      $error("FAIL %s: got de=%b data=%h ctrl=%b locked=%b shift=%0d, expected all zero",
             tag, bus.de, bus.data_out, bus.ctrl_out, bus.locked, bus.bit_shift);
    end
  endtask

  task automatic check_shift(input logic [3:0] want, input string tag);
    n_checks++;
    assert (bus.bit_shift === want)
    else begin
      n_fail++;
      $error("FAIL %s: got bit_shift=%0d, expected %0d", tag, bus.bit_shift, want);
    end
  endtask

  initial begin
    logic [7:0] r;
    logic [9:0] rot;
    int         lock_at;

    bus.tmds_in = 10'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk_pix);
    #1;
    check_zero("reset_state");
    rst = 1'b0;
    model_reset();

    // Pre-aligned stream: 20 tokens then 8'hA5
    repeat (20) tick(TOK[0], 8'h00, "prealign_tok");
    tick(enc_data(8'hA5), 8'hA5, "prealign_a5");
    repeat (3) tick(TOK[0], 8'h00, "prealign_flush");

    // Control decode then ctrl hold across data
    for (int t = 0; t < 4; t++) tick(TOK[t], 8'h00, "ctrl_tok");
    for (int k = 0; k < 4; k++) begin
      r = 8'($urandom);
      tick(enc_data(r), r, "ctrl_hold");
    end

    // Full byte sweep with randomised disparity choices
    for (int v = 0; v < 256; v++) tick(enc_data(8'(v)), 8'(v), "sweep");

    // Random mix of tokens and data
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 7) == 0) tick(TOK[$urandom_range(0, 3)], 8'h00, "mix_tok");
      else begin
        r = 8'($urandom);
        tick(enc_data(r), r, "mix_data");
      end
    end

    // Loss of lock after LOSS_TIMEOUT data words, then re-lock at the same offset
    tick(TOK[1], 8'h00, "loss_pre");
    for (int k = 0; k < LOSS_TIMEOUT + 2; k++) begin
      r = 8'($urandom);
      tick(enc_data(r), r, "loss_data");
    end
    repeat (TOKEN_RUN + 4) tick(TOK[2], 8'h00, "relock_tok");

    // Asynchronous reset mid-cycle while locked
    @(posedge clk_pix);
    #3;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    @(posedge clk_pix);
    #1;
    check_zero("reset_held");
    rst = 1'b0;
    model_reset();
    repeat (TOKEN_RUN + 4) tick(TOK[3], 8'h00, "post_reset_tok");
    r = 8'h3C;
    tick(enc_data(r), r, "post_reset_data");
    repeat (2) tick(TOK[3], 8'h00, "post_reset_flush");

    // Bit-rotated stream: boundary sits at window bit 3
    rst = 1'b1;
    @(posedge clk_pix);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) rot[i] = TOK[0][(i + 7) % 10];
    bus.tmds_in = rot;
    lock_at = 0;
    for (int n = 1; n <= 5000 && lock_at == 0; n++) begin
      @(posedge clk_pix);
      #1;
      if (n == 1000) check_shift(4'd0, "rot_shift0");
      if (n == 1030) check_shift(4'd1, "rot_shift1");
      if (n == 2060) check_shift(4'd2, "rot_shift2");
      if (n == 3080) check_shift(4'd3, "rot_shift3");
      if (bus.locked === 1'b1) lock_at = n;
    end
    n_checks++;
    assert (lock_at >= 3086 && lock_at <= 3094)
    else begin
      n_fail++;
      $error("FAIL rot_lock_time: got lock at cycle %0d, expected 3086..3094", lock_at);
    end
    check_shift(4'd3, "rot_final_shift");
    repeat (40) @(posedge clk_pix);
    #1;
    n_checks++;
    assert ({bus.locked, bus.de, bus.ctrl_out, bus.bit_shift} === {1'b1, 1'b0, 2'b00, 4'd3})
    else begin
      n_fail++;
      $error("FAIL rot_hold: got locked=%b de=%b ctrl=%b shift=%0d, expected locked=1 de=0 ctrl=00 shift=3",
             bus.locked, bus.de, bus.ctrl_out, bus.bit_shift);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
